// File: rtl/traffic_gen2_pkg.sv
// Shared phase encoding and lamp patterns for the gen2 traffic controller.
package traffic_gen2_pkg;

    typedef enum logic [2:0] {
        HWY_G  = 3'd0,
        HWY_Y  = 3'd1,
        CLR_1  = 3'd2,
        FARM_G = 3'd3,
        FARM_Y = 3'd4,
        CLR_2  = 3'd5
    } phase_t;

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

endpackage

// File: rtl/tl_phase_timer.sv
// Phase dwell down-counter: loads on phase entry, saturates at zero.
module tl_phase_timer #(
    parameter int unsigned          CNT_W   = 4,
    parameter logic [CNT_W-1:0]     RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= RST_VAL;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/traffic_ctrl_gen2.sv
// Highway/farmway traffic light controller with all-red clearance and farm green extension.
// Optional pedestrian walk phase enabled by defining TRAFFIC_PED_EN.
module traffic_ctrl_gen2
    import traffic_gen2_pkg::*;
#(
    parameter int unsigned CNT_W      = 4,
    parameter int unsigned HWY_MIN_G  = 8,
    parameter int unsigned YEL        = 3,
    parameter int unsigned RED_CLR    = 1,
    parameter int unsigned FARM_MIN_G = 4,
    parameter int unsigned FARM_MAX_G = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sensor,
    output logic [2:0]       highway,
    output logic [2:0]       farmway,
    output phase_t           state,
    output logic [CNT_W-1:0] count
`ifdef TRAFFIC_PED_EN
    ,
    input  logic             ped_req,
    output logic             walk
`endif
);

    localparam logic [CNT_W-1:0] HWY_LD  = CNT_W'(HWY_MIN_G - 1);
    localparam logic [CNT_W-1:0] YEL_LD  = CNT_W'(YEL - 1);
    localparam logic [CNT_W-1:0] CLR_LD  = CNT_W'(RED_CLR - 1);
    localparam logic [CNT_W-1:0] FARM_LD = CNT_W'(FARM_MIN_G - 1);
    localparam logic [CNT_W-1:0] EXT_MAX = CNT_W'(FARM_MAX_G - FARM_MIN_G);

    phase_t           next_state;
    logic             load;
    logic             zero;
    logic             demand;
    logic [CNT_W-1:0] ld_val;
    logic [CNT_W-1:0] ext;

`ifdef TRAFFIC_PED_EN
    logic ped_pend;

    // A request arriving on the FARM_G entry edge is kept for the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ped_pend <= 1'b0;
        end else if (state != FARM_G && next_state == FARM_G) begin
            ped_pend <= ped_req;
        end else if (ped_req) begin
            ped_pend <= 1'b1;
        end
    end

    assign demand = sensor | ped_pend;
    assign walk   = (state == FARM_G);
`else
    assign demand = sensor;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HWY_G;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext <= '0;
        end else if (state == FARM_G && next_state == FARM_G) begin
            if (zero) begin
                ext <= ext + 1'b1;
            end
        end else begin
            ext <= '0;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            HWY_G:   if (zero && demand)                     next_state = HWY_Y;
            HWY_Y:   if (zero)                               next_state = CLR_1;
            CLR_1:   if (zero)                               next_state = FARM_G;
            FARM_G:  if (zero && (!sensor || ext == EXT_MAX)) next_state = FARM_Y;
            FARM_Y:  if (zero)                               next_state = CLR_2;
            CLR_2:   if (zero)                               next_state = HWY_G;
            default:                                         next_state = HWY_G;
        endcase
    end

    always_comb begin
        load   = (next_state != state);
        ld_val = HWY_LD;
        case (next_state)
            HWY_Y, FARM_Y: ld_val = YEL_LD;
            CLR_1, CLR_2:  ld_val = CLR_LD;
            FARM_G:        ld_val = FARM_LD;
            default:       ld_val = HWY_LD;
        endcase
    end

    tl_phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (HWY_LD)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .value (ld_val),
        .count (count),
        .zero  (zero)
    );

    // Illegal codes show all-red until the next edge returns to HWY_G.
    always_comb begin
        highway = LAMP_R;
        farmway = LAMP_R;
        case (state)
            HWY_G:   highway = LAMP_G;
            HWY_Y:   highway = LAMP_Y;
            FARM_G:  farmway = LAMP_G;
            FARM_Y:  farmway = LAMP_Y;
            default: ;
        endcase
    end

endmodule
